// File: rtl/awgn_channel_combiner_if.sv
// Bundle of the sample, noise-generator and channel-output signals of the AWGN combiner.
// The master drives the sample, control and noise-generator inputs; the slave is the combiner itself.
interface awgn_channel_combiner_if #(
    parameter int SAT_CNT_WIDTH = 16
);
    logic [11:0]              s_i;
    logic [11:0]              s_q;
    logic                     s_valid;
    logic                     s_sof;
    logic                     bypass;
    logic [7:0]               mag_in;
    logic                     mag_load;
    logic                     cnt_clr;
    logic [11:0]              noise_i;
    logic                     noise_i_valid;
    logic [11:0]              noise_q;
    logic                     noise_q_valid;
    logic                     noise_en;
    logic [7:0]               noise_magnitude;
    logic [11:0]              ch_i;
    logic [11:0]              ch_q;
    logic                     ch_valid;
    logic                     ch_sof;
    logic [SAT_CNT_WIDTH-1:0] sat_count;
    logic                     align_err;

    modport master (
        output s_i, s_q, s_valid, s_sof, bypass, mag_in, mag_load, cnt_clr,
               noise_i, noise_i_valid, noise_q, noise_q_valid,
        input  noise_en, noise_magnitude, ch_i, ch_q, ch_valid, ch_sof,
               sat_count, align_err
    );

    modport slave (
        input  s_i, s_q, s_valid, s_sof, bypass, mag_in, mag_load, cnt_clr,
               noise_i, noise_i_valid, noise_q, noise_q_valid,
        output noise_en, noise_magnitude, ch_i, ch_q, ch_valid, ch_sof,
               sat_count, align_err
    );
endinterface

// File: rtl/awgn_channel_combiner.sv
// Delays the clean 16-QAM I/Q stream to meet the generator noise, adds it with Q1.11 saturation,
// counts clips and commits noise-magnitude changes only on frame or idle boundaries.
module awgn_channel_combiner #(
    parameter int         NOISE_LATENCY = 3,
    parameter logic [7:0] MAG_RESET     = 8'd0,
    parameter int         SAT_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    awgn_channel_combiner_if.slave bus
);
    localparam logic [11:0] POS_MAX = 12'h7FF;
    localparam logic [11:0] NEG_MIN = 12'h800;

    // Returns {clipped, saturated Q1.11 sum}.
    function automatic logic [12:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {a[11], a} + {b[11], b};
        if (s[12] != s[11]) begin
            sat_add = {1'b1, (s[12] ? NEG_MIN : POS_MAX)};
        end else begin
            sat_add = {1'b0, s[11:0]};
        end
    endfunction

    logic [11:0]              dl_si_q [NOISE_LATENCY];
    logic [11:0]              dl_sq_q [NOISE_LATENCY];
    logic [NOISE_LATENCY-1:0] dl_v_q;
    logic [NOISE_LATENCY-1:0] dl_sof_q;

    logic [11:0]              ch_i_q, ch_q_q, ch_i_d, ch_q_d;
    logic                     ch_valid_q, ch_sof_q, align_err_q;
    logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;
    logic [7:0]               mag_q, pend_val_q;
    logic                     pending_q;

    logic                     dv_s, noise_ok_s, align_hit_s, commit_ok_s;
    logic [11:0]              ni_s, nq_s, di_s, dq_s;
    logic [12:0]              res_i_s, res_q_s;
    logic [1:0]               inc_s;
    logic [SAT_CNT_WIDTH:0]   cnt_sum_s;

    assign bus.noise_en        = bus.s_valid;
    assign bus.noise_magnitude = mag_q;
    assign bus.ch_i            = ch_i_q;
    assign bus.ch_q            = ch_q_q;
    assign bus.ch_valid        = ch_valid_q;
    assign bus.ch_sof          = ch_sof_q;
    assign bus.sat_count       = sat_count_q;
    assign bus.align_err       = align_err_q;

    assign dv_s = dl_v_q[NOISE_LATENCY-1];
    assign di_s = dl_si_q[NOISE_LATENCY-1];
    assign dq_s = dl_sq_q[NOISE_LATENCY-1];

    // Signal delay line matching the generator noise latency; shifts every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NOISE_LATENCY; k++) begin
                dl_si_q[k] <= 12'd0;
                dl_sq_q[k] <= 12'd0;
            end
            dl_v_q   <= {NOISE_LATENCY{1'b0}};
            dl_sof_q <= {NOISE_LATENCY{1'b0}};
        end else begin
            dl_si_q[0] <= bus.s_i;
            dl_sq_q[0] <= bus.s_q;
            for (int k = 1; k < NOISE_LATENCY; k++) begin
                dl_si_q[k] <= dl_si_q[k-1];
                dl_sq_q[k] <= dl_sq_q[k-1];
            end
            dl_v_q   <= {dl_v_q[NOISE_LATENCY-2:0], bus.s_valid};
            dl_sof_q <= {dl_sof_q[NOISE_LATENCY-2:0], bus.s_valid & bus.s_sof};
        end
    end

    // Combine: a misaligned sample gets zero noise on both channels.
    always_comb begin
        noise_ok_s  = bus.noise_i_valid & bus.noise_q_valid;
        ni_s        = noise_ok_s ? bus.noise_i : 12'd0;
        nq_s        = noise_ok_s ? bus.noise_q : 12'd0;
        res_i_s     = sat_add(di_s, ni_s);
        res_q_s     = sat_add(dq_s, nq_s);
        align_hit_s = dv_s & ~bus.bypass & ~noise_ok_s;
        if (bus.bypass) begin
            ch_i_d = di_s;
            ch_q_d = dq_s;
            inc_s  = 2'd0;
        end else begin
            ch_i_d = res_i_s[11:0];
            ch_q_d = res_q_s[11:0];
            inc_s  = {1'b0, res_i_s[12]} + {1'b0, res_q_s[12]};
        end
    end

    // Saturating clip counter; clear beats a same-cycle increment.
    always_comb begin
        cnt_sum_s = {1'b0, sat_count_q} + {{(SAT_CNT_WIDTH-1){1'b0}}, inc_s};
        if (bus.cnt_clr) begin
            sat_count_d = {SAT_CNT_WIDTH{1'b0}};
        end else if (!dv_s) begin
            sat_count_d = sat_count_q;
        end else if (cnt_sum_s[SAT_CNT_WIDTH]) begin
            sat_count_d = {SAT_CNT_WIDTH{1'b1}};
        end else begin
            sat_count_d = cnt_sum_s[SAT_CNT_WIDTH-1:0];
        end
    end

    // Output registers; data holds when no delayed sample is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_i_q      <= 12'd0;
            ch_q_q      <= 12'd0;
            ch_valid_q  <= 1'b0;
            ch_sof_q    <= 1'b0;
            sat_count_q <= {SAT_CNT_WIDTH{1'b0}};
            align_err_q <= 1'b0;
        end else begin
            ch_valid_q  <= dv_s;
            ch_sof_q    <= dl_sof_q[NOISE_LATENCY-1];
            sat_count_q <= sat_count_d;
            align_err_q <= align_err_q | align_hit_s;
            if (dv_s) begin
                ch_i_q <= ch_i_d;
                ch_q_q <= ch_q_d;
            end
        end
    end

    assign commit_ok_s = (bus.s_valid & bus.s_sof) |
                         (~bus.s_valid & (dl_v_q == {NOISE_LATENCY{1'b0}}));

    // A fresh load always wins, so a load never commits in its own cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q      <= MAG_RESET;
            pend_val_q <= 8'd0;
            pending_q  <= 1'b0;
        end else if (bus.mag_load) begin
            pend_val_q <= bus.mag_in;
            pending_q  <= 1'b1;
        end else if (pending_q && commit_ok_s) begin
            mag_q     <= pend_val_q;
            pending_q <= 1'b0;
        end
    end
endmodule
